// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM generator/capture pair.
// PWM_PERIOD matches the generator so loopback readings can be compared directly.
package pwm_pkg;

  localparam int CNT_W      = 13;
  localparam int PWM_PERIOD = 5000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } capState_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by a rise/fall detector
// on the synchronized level. Reusable for any slow external input.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sDly_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      sDly_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      sDly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~sDly_q;
  assign fall_o = ~s_o & sDly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an external PWM line in clk_in
// cycles, and flags the signal as lost when an expected edge does not arrive in time.
module pwm_capture #(
  parameter int CNT_W       = pwm_pkg::CNT_W,
  parameter int TIMEOUT     = 8191,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             sig_lost,
  output logic             stuck_level
);

  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic sLevel, rise, fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_i  (pwm_in),
    .s_o    (sLevel),
    .rise_o (rise),
    .fall_o (fall)
  );

  capState_e        state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, hiLen_q, duty_q, period_q;
  logic             valid_q, lost_q, stuck_q;

  // Counter saturates at the timeout value so a dead line can never wrap into a fake edge.
  assign cnt_d = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + ONE_C;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hiLen_q  <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b1;
      stuck_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise) begin
            cnt_q   <= ONE_C;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hiLen_q <= cnt_q;
            cnt_q   <= cnt_d;
            state_q <= LOW;
          end else if (cnt_q == TIMEOUT_C) begin
            cnt_q   <= '0;
            lost_q  <= 1'b1;
            stuck_q <= sLevel;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        LOW: begin
          // An edge arriving on the timeout cycle still counts as a normal transition.
          if (rise) begin
            period_q <= cnt_q;
            duty_q   <= hiLen_q;
            valid_q  <= 1'b1;
            lost_q   <= 1'b0;
            cnt_q    <= ONE_C;
            state_q  <= HIGH;
          end else if (cnt_q == TIMEOUT_C) begin
            cnt_q   <= '0;
            lost_q  <= 1'b1;
            stuck_q <= sLevel;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign duty_cnt    = duty_q;
  assign period_cnt  = period_q;
  assign meas_valid  = valid_q;
  assign sig_lost    = lost_q;
  assign stuck_level = stuck_q;

endmodule
